// File: rtl/cache_controller_if.sv
// MEM-stage, cache and SRAM-controller signals of the cache controller, plus load statistics.
// slave = controller side, master = environment (pipeline, cache array, SRAM controller).
interface cache_controller_if;
  logic [31:0] address;
  logic [31:0] wdata;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic [31:0] rdata;
  logic        ready;

  logic [16:0] cache_address;
  logic [63:0] cache_write_data;
  logic        cache_read_en;
  logic        cache_write_en;
  logic        check_invalid;
  logic        hit;
  logic [31:0] cache_read_data;

  logic [31:0] sram_address;
  logic [31:0] sram_wdata;
  logic        sram_read_en;
  logic        sram_write_en;
  logic [63:0] sram_rdata;
  logic        sram_ready;

  logic [15:0] hit_count;
  logic [15:0] miss_count;

  modport slave (
    input  address, wdata, MEM_R_EN, MEM_W_EN, hit, cache_read_data, sram_rdata, sram_ready,
    output rdata, ready, cache_address, cache_write_data, cache_read_en, cache_write_en,
           check_invalid, sram_address, sram_wdata, sram_read_en, sram_write_en,
           hit_count, miss_count
  );

  modport master (
    output address, wdata, MEM_R_EN, MEM_W_EN, hit, cache_read_data, sram_rdata, sram_ready,
    input  rdata, ready, cache_address, cache_write_data, cache_read_en, cache_write_en,
           check_invalid, sram_address, sram_wdata, sram_read_en, sram_write_en,
           hit_count, miss_count
  );
endinterface

// File: rtl/cache_controller.sv
// Write-through, no-allocate cache controller between the MEM stage, a cache array and an SRAM controller.
// Optional saturating hit/miss counters are built when CACHE_CTRL_STATS_EN is defined.
module cache_controller #(
  parameter logic [31:0] BASE_ADDR = 32'd1024
) (
  input  logic              clk,
  input  logic              rst,
  cache_controller_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ_MISS, WRITE} state_e;

  state_e      state_q, state_d;
  logic [31:0] eff;
  logic [31:0] rdata_c;
  logic        ready_c, c_rd_c, c_wr_c, c_inv_c, s_rd_c, s_wr_c;

  assign eff                  = bus.address - BASE_ADDR;
  assign bus.sram_address     = eff;
  assign bus.cache_address    = eff[18:2];
  assign bus.sram_wdata       = bus.wdata;
  assign bus.cache_write_data = bus.sram_rdata;

  assign bus.rdata          = rdata_c;
  assign bus.ready          = ready_c;
  assign bus.cache_read_en  = c_rd_c;
  assign bus.cache_write_en = c_wr_c;
  assign bus.check_invalid  = c_inv_c;
  assign bus.sram_read_en   = s_rd_c;
  assign bus.sram_write_en  = s_wr_c;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Request inputs are held by the MEM stage while ready=0, so nothing is latched here.
  always_comb begin
    state_d = state_q;
    ready_c = 1'b1;
    rdata_c = '0;
    c_rd_c  = 1'b0;
    c_wr_c  = 1'b0;
    c_inv_c = 1'b0;
    s_rd_c  = 1'b0;
    s_wr_c  = 1'b0;
    if (rst) begin
      case (state_q)
        IDLE: begin
          if (bus.MEM_W_EN) begin
            c_inv_c = 1'b1;
            ready_c = 1'b0;
            state_d = WRITE;
          end else if (bus.MEM_R_EN) begin
            if (bus.hit) begin
              c_rd_c  = 1'b1;
              rdata_c = bus.cache_read_data;
            end else begin
              ready_c = 1'b0;
              state_d = READ_MISS;
            end
          end
        end
        READ_MISS: begin
          s_rd_c  = 1'b1;
          ready_c = 1'b0;
          if (bus.sram_ready) begin
            c_wr_c  = 1'b1;
            rdata_c = eff[2] ? bus.sram_rdata[63:32] : bus.sram_rdata[31:0];
            ready_c = 1'b1;
            state_d = IDLE;
          end
        end
        WRITE: begin
          s_wr_c  = 1'b1;
          ready_c = 1'b0;
          if (bus.sram_ready) begin
            ready_c = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef CACHE_CTRL_STATS_EN
  logic [15:0] hit_q, hit_d, miss_q, miss_d;
  logic        miss_evt;

  // cache_read_en only rises on zero-stall hit cycles, so it doubles as the hit event.
  assign miss_evt = rst && (state_q == IDLE) && (state_d == READ_MISS);

  always_comb begin
    hit_d  = hit_q;
    miss_d = miss_q;
    if (c_rd_c && hit_q != 16'hFFFF)    hit_d  = hit_q + 16'd1;
    if (miss_evt && miss_q != 16'hFFFF) miss_d = miss_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      hit_q  <= hit_d;
      miss_q <= miss_d;
    end
  end

  assign bus.hit_count  = hit_q;
  assign bus.miss_count = miss_q;
`else
  assign bus.hit_count  = '0;
  assign bus.miss_count = '0;
`endif
endmodule
